// File: rtl/score_display_mux_pkg.sv
// Shared segment patterns, digit index type and anode helpers for the score display.
// Pure declarations; no timing or flow control.
// No backpressure: constants only.
package score_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t IDX_RESET = 2'd3;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // idx0 drives an[3], idx3 drives an[0]
    function automatic logic [3:0] an_onehot(digit_idx_t idx);
        return ~(4'b1000 >> idx);
    endfunction

endpackage

// File: rtl/score_display_mux_if.sv
// Score inputs and display pins bundled for the score display mux.
// No latency; wires only.
// No backpressure: scores are level inputs, display pins are free-running outputs.
interface score_display_mux_if;
    logic [3:0] p1_tens;
    logic [3:0] p1_ones;
    logic [3:0] p2_tens;
    logic [3:0] p2_ones;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    modport master (
        output p1_tens, p1_ones, p2_tens, p2_ones,
        input  seg, an, dp
    );

    modport slave (
        input  p1_tens, p1_ones, p2_tens, p2_ones,
        output seg, an, dp
    );
endinterface

// File: rtl/score_display_mux_bcd_to_seg7.sv
// BCD digit to active-low seven-segment pattern; non-BCD codes show a dash.
// Combinational, zero latency.
// No backpressure.
module bcd_to_seg7
    import score_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/score_display_mux.sv
// Four-digit multiplexed score display; snapshots both scores once per frame. Option: LEADING_ZERO_BLANK_EN.
// Outputs registered on each scan tick; each digit lit SCAN_DIV cycles, frame 4*SCAN_DIV.
// No backpressure: free-running scan, inputs sampled at frame start.
module score_display_mux
    import score_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic               clk,
    input  logic               reset,
    score_display_mux_if.slave bus
);
    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] r_div;
    digit_idx_t       r_idx;
    logic [15:0]      r_snap;
    logic [6:0]       r_seg;
    logic [3:0]       r_an;
    logic             r_dp;

    logic             w_tick;
    digit_idx_t       w_idx_nxt;
    logic [15:0]      w_live;
    logic [3:0]       w_digit;
    logic [6:0]       w_seg_dec;
    logic [6:0]       w_seg;

    always_comb begin
        w_tick    = (r_div == DIV_LAST);
        w_idx_nxt = r_idx + 2'd1;
        w_live    = {bus.p1_tens, bus.p1_ones, bus.p2_tens, bus.p2_ones};
        // Frame-start digit comes from the live inputs, since the snapshot loads on this same edge
        case (w_idx_nxt)
            2'd0:    w_digit = bus.p1_tens;
            2'd1:    w_digit = r_snap[11:8];
            2'd2:    w_digit = r_snap[7:4];
            default: w_digit = r_snap[3:0];
        endcase
    end

    bcd_to_seg7 u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg_dec)
    );

    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        // Even indices are tens digits
        w_seg = (!w_idx_nxt[0] && (w_digit == 4'd0)) ? SEG_BLANK : w_seg_dec;
`else
        w_seg = w_seg_dec;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div  <= '0;
            r_idx  <= IDX_RESET;
            r_snap <= '0;
            r_seg  <= SEG_BLANK;
            r_an   <= AN_OFF;
            r_dp   <= 1'b1;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_ONE;
            if (w_tick) begin
                r_idx <= w_idx_nxt;
                if (w_idx_nxt == 2'd0) begin
                    r_snap <= w_live;
                end
                r_seg <= w_seg;
                r_an  <= an_onehot(w_idx_nxt);
                r_dp  <= (w_idx_nxt == 2'd1) ? 1'b0 : 1'b1;
            end
        end
    end

    assign bus.seg = r_seg;
    assign bus.an  = r_an;
    assign bus.dp  = r_dp;

endmodule

// File: tb/tb_score_display_mux.sv
// Bench for score_display_mux at SCAN_DIV=4: vector table, directed corner sequences, random run vs. a slot-arithmetic model.
module tb_score_display_mux;
    localparam int SD = 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZB = 7'h7F;
`else
    localparam logic [6:0] ZB = 7'h40;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    score_display_mux_if bus();

    score_display_mux #(.SCAN_DIV(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: n = edges since reset released, snapshot per digit slot
    int         n = 0;
    logic [3:0] snap [4];
    logic [6:0] seg_tab [16];

    typedef struct {
        logic [15:0] digs;   // {p1_tens, p1_ones, p2_tens, p2_ones}
        logic [27:0] segs;   // expected seg for idx0..idx3
    } vec_t;
    vec_t tab [5];

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got an/dp/seg=%b/%b/%h, want %b/%b/%h", name, $time,
                     act[11:8], act[7], act[6:0], exp[11:8], exp[7], exp[6:0]);
        end
    endtask

    function automatic logic [3:0] an_of(input int k);
        logic [3:0] a;
        a = 4'hF;
        a[3-k] = 1'b0;
        return a;
    endfunction

    task automatic model_edge();
        if (reset) begin
            n = 0;
            for (int i = 0; i < 4; i++) snap[i] = 4'h0;
        end else begin
            n++;
            if (n >= SD && ((n - SD) % (4 * SD)) == 0) begin
                snap[0] = bus.p1_tens;
                snap[1] = bus.p1_ones;
                snap[2] = bus.p2_tens;
                snap[3] = bus.p2_ones;
            end
        end
    endtask

    function automatic logic [11:0] exp_out();
        int         idx;
        logic [3:0] d;
        logic [6:0] s;
        if (n < SD) return {4'hF, 1'b1, 7'h7F};
        idx = ((n - SD) / SD) % 4;
        d   = snap[idx];
        s   = seg_tab[d];
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx == 0 || idx == 2) && d == 4'd0) s = 7'h7F;
`endif
        return {an_of(idx), (idx == 1) ? 1'b0 : 1'b1, s};
    endfunction

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk(tag, {bus.an, bus.dp, bus.seg}, exp_out());
        @(negedge clk);
    endtask

    task automatic steps(input int k, input string tag);
        for (int i = 0; i < k; i++) step(tag);
    endtask

    task automatic set_digs(input logic [15:0] d);
        {bus.p1_tens, bus.p1_ones, bus.p2_tens, bus.p2_ones} = d;
    endtask

    task automatic slot_chk(input string name, input int k, input logic [6:0] s);
        chk(name, {bus.an, bus.dp, bus.seg}, {an_of(k), (k == 1) ? 1'b0 : 1'b1, s});
    endtask

    initial begin
        logic [15:0] d;
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'h3F;

        tab[0] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}};
        tab[1] = '{16'hC500, {7'h3F, 7'h12, ZB,    7'h40}};
        tab[2] = '{16'h0005, {ZB,    7'h40, ZB,    7'h12}};
        tab[3] = '{16'h9876, {7'h10, 7'h00, 7'h78, 7'h02}};
        tab[4] = '{16'hAFB3, {7'h3F, 7'h3F, 7'h3F, 7'h30}};

        set_digs(16'h1234);
        @(negedge clk);

        // Reset held 3 cycles, then first tick on the SD-th edge after release
        reset = 1'b1;
        steps(3, "reset_hold");
        chk("reset_vals", {bus.an, bus.dp, bus.seg}, {4'hF, 1'b1, 7'h7F});
        reset = 1'b0;
        steps(SD - 1, "pre_tick");
        chk("pre_tick_off", {bus.an, bus.dp, bus.seg}, {4'hF, 1'b1, 7'h7F});
        step("first_tick");
        slot_chk("first_tick_idx0", 0, 7'h79);

        // Table: each score pattern over one full frame, checked at slot start and end
        for (int v = 0; v < 5; v++) begin
            set_digs(tab[v].digs);
            reset = 1'b1;
            step("tab_reset");
            reset = 1'b0;
            steps(SD, "tab_lead");
            for (int k = 0; k < 4; k++) begin
                slot_chk($sformatf("tab%0d_slot%0d_start", v, k), k, tab[v].segs[27-7*k -: 7]);
                steps(SD - 1, "tab_hold");
                slot_chk($sformatf("tab%0d_slot%0d_end", v, k), k, tab[v].segs[27-7*k -: 7]);
                step("tab_next");
            end
        end

        // Mid-frame change of p2_ones must wait for the next frame
        set_digs(16'h1234);
        reset = 1'b1;
        step("mid_reset");
        reset = 1'b0;
        steps(SD, "mid_lead");
        steps(SD + 1, "mid_run");
        bus.p2_ones = 4'd9;
        steps(SD - 1, "mid_run");
        steps(SD, "mid_run");
        slot_chk("mid_idx3_old", 3, 7'h19);
        steps(4 * SD, "mid_run");
        slot_chk("mid_idx3_new", 3, 7'h10);

        // Reset during idx2 slot, scan restarts at idx0 SD cycles after release
        steps(3 * SD + 1, "rst2_run");
        chk("rst2_in_idx2", {bus.an[1], bus.dp}, {1'b0, 1'b1});
        reset = 1'b1;
        step("rst2_edge");
        chk("rst2_forced", {bus.an, bus.dp, bus.seg}, {4'hF, 1'b1, 7'h7F});
        reset = 1'b0;
        steps(SD - 1, "rst2_wait");
        chk("rst2_still_off", {bus.an, bus.dp, bus.seg}, {4'hF, 1'b1, 7'h7F});
        step("rst2_restart");
        slot_chk("rst2_idx0", 0, 7'h79);

        // Random scores and occasional resets against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                d = 16'($urandom);
                set_digs(d);
            end
            reset = ($urandom_range(0, 249) == 0);
            step("random");
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
